// File: rtl/mux_scan.sv
// ============================================================================
// mux_scan: N-channel registered mux with manual select and auto-scan dwell.
// Optional build macro MUX_SCAN_MASK_EN adds chan_mask for masked scanning.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*WIDTH-1:0]  din,
  input  logic                       mode,
  input  logic [SELW-1:0]            sel_in,
  input  logic                       load_sel,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]        chan_mask,
`endif
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [SELW-1:0]            sel_out,
  output logic                       wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SELW-1:0]  SEL_LAST   = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]    CHAN_COUNT = (SELW + 1)'(CHANNELS);

  logic [SELW-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             wrap_q, wrap_d;

  logic             load_ok;
  logic             dwell_done;
  logic             any_enabled;
  logic [SELW-1:0]  next_sel;
  logic             next_wraps;
  logic [WIDTH-1:0] sel_word;

  // Compare-based word select keeps non-power-of-two channel counts in range.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_q == SELW'(i)) begin
        sel_word = din[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_SCAN_MASK_EN
  logic [SELW:0] cand;
  logic          found;

  // Search upward from sel_q+1, wrapping, for the first enabled channel.
  always_comb begin
    next_sel = sel_q;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = {1'b0, sel_q} + (SELW + 1)'(i);
      if (cand >= CHAN_COUNT) begin
        cand = cand - CHAN_COUNT;
      end
      if (!found && chan_mask[cand[SELW-1:0]]) begin
        found    = 1'b1;
        next_sel = cand[SELW-1:0];
      end
    end
    any_enabled = |chan_mask;
    next_wraps  = (next_sel <= sel_q);
  end
`else
  always_comb begin
    next_sel    = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
    next_wraps  = (sel_q == SEL_LAST);
    any_enabled = 1'b1;
  end
`endif

  always_comb begin
    load_ok      = load_sel && ({1'b0, sel_in} < CHAN_COUNT);
    dwell_done   = (cnt_q == DWELL_LAST);
    sel_d        = sel_q;
    cnt_d        = '0;
    wrap_d       = 1'b0;
    dout_d       = sel_word;
    dout_valid_d = any_enabled;

    if (mode) begin
      // A load wins over a coincident advance and restarts the dwell.
      if (load_ok) begin
        sel_d = sel_in;
      end else if (!any_enabled) begin
        sel_d = sel_q;
      end else if (dwell_done) begin
        sel_d  = next_sel;
        wrap_d = next_wraps;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (load_ok) begin
      sel_d = sel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sel_out    = sel_q;
  assign wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// ============================================================================
// tb_mux_scan: vector table with scoreboard queue for mux_scan.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        mode;
  logic [1:0]  sel_in;
  logic        load_sel;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [1:0]  sel_out;
  logic        wrap;

  logic [23:0] c3_din;
  logic        c3_mode;
  logic [1:0]  c3_sel_in;
  logic        c3_load;
  logic [7:0]  c3_dout;
  logic        c3_valid;
  logic [1:0]  c3_sel_out;
  logic        c3_wrap;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  chan_mask;
  logic [2:0]  c3_mask;
`endif

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode),
    .sel_in(sel_in), .load_sel(load_sel),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .dout(dout), .dout_valid(dout_valid), .sel_out(sel_out), .wrap(wrap)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_c3 (
    .clk(clk), .rst_n(rst_n), .din(c3_din), .mode(c3_mode),
    .sel_in(c3_sel_in), .load_sel(c3_load),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(c3_mask),
`endif
    .dout(c3_dout), .dout_valid(c3_valid), .sel_out(c3_sel_out), .wrap(c3_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       mode;
    logic       load;
    logic [1:0] sel_in;
    logic [1:0] e_sel;
    logic [7:0] e_dout;
    logic       e_valid;
    logic       e_wrap;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] dout;
    logic       valid;
    logic       wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic r, input logic m, input logic l,
                              input logic [1:0] s, input logic [1:0] es,
                              input logic [7:0] ed, input logic ev,
                              input logic ew);
    vec_t v;
    v.rst_n = r; v.mode = m; v.load = l; v.sel_in = s;
    v.e_sel = es; v.e_dout = ed; v.e_valid = ev; v.e_wrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    din       = {8'h44, 8'h33, 8'h22, 8'h11};
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel_in    = 2'd3;
    load_sel  = 1'b1;
    c3_din    = {8'hC3, 8'hB2, 8'hA1};
    c3_mode   = 1'b0;
    c3_sel_in = 2'd0;
    c3_load   = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    chan_mask = 4'b1111;
    c3_mask   = 3'b111;
`endif

    // Reset held with arbitrary inputs, then manual load of channel 2.
    for (int i = 0; i < 3; i++) add(0, 1, 1, 3, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 0, 8'h11, 1, 0);
    add(1, 0, 1, 2, 2, 8'h11, 1, 0);
    add(1, 0, 0, 0, 2, 8'h33, 1, 0);
    add(1, 0, 0, 0, 2, 8'h33, 1, 0);
    // Auto scan from reset.
    add(0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 0, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h22, 1, 0);
    add(1, 1, 0, 0, 2, 8'h22, 1, 0);
    add(1, 1, 0, 0, 2, 8'h33, 1, 0);
    add(1, 1, 0, 0, 3, 8'h33, 1, 0);
    add(1, 1, 0, 0, 3, 8'h44, 1, 0);
    add(1, 1, 0, 0, 0, 8'h44, 1, 1);
    add(1, 1, 0, 0, 0, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h22, 1, 0);
    // Load collides with advance on channel 1.
    add(1, 1, 1, 3, 3, 8'h22, 1, 0);
    add(1, 1, 0, 0, 3, 8'h44, 1, 0);
    add(1, 1, 0, 0, 0, 8'h44, 1, 1);
    add(1, 1, 0, 0, 0, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h22, 1, 0);
    add(1, 1, 0, 0, 2, 8'h22, 1, 0);
    // Freeze on channel 2 in manual mode.
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 2, 8'h33, 1, 0);
    // Reset mid-dwell.
    add(1, 1, 0, 0, 2, 8'h33, 1, 0);
    add(0, 1, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 0, 8'h11, 1, 0);
    add(1, 1, 0, 0, 1, 8'h11, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      mode     = vecs[i].mode;
      load_sel = vecs[i].load;
      sel_in   = vecs[i].sel_in;
      x.sel = vecs[i].e_sel; x.dout = vecs[i].e_dout;
      x.valid = vecs[i].e_valid; x.wrap = vecs[i].e_wrap;
      sb.push_back(x);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d sel_out", i), 32'(sel_out), 32'(e.sel));
      check($sformatf("vec%0d dout", i), 32'(dout), 32'(e.dout));
      check($sformatf("vec%0d dout_valid", i), 32'(dout_valid), 32'(e.valid));
      check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(e.wrap));
    end
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    // Three-channel instance: an out-of-range load is ignored.
    @(negedge clk);
    mode = 1'b0; load_sel = 1'b0;
    c3_load = 1'b1; c3_sel_in = 2'd1;
    @(posedge clk); #1;
    check("c3 load 1 sel_out", 32'(c3_sel_out), 32'd1);
    @(negedge clk);
    c3_sel_in = 2'd3;
    @(posedge clk); #1;
    check("c3 illegal load sel_out", 32'(c3_sel_out), 32'd1);
    check("c3 illegal load dout", 32'(c3_dout), 32'hB2);
    @(negedge clk);
    c3_sel_in = 2'd2;
    @(posedge clk); #1;
    check("c3 load 2 sel_out", 32'(c3_sel_out), 32'd2);
    @(negedge clk);
    c3_load = 1'b0;
    @(posedge clk); #1;
    check("c3 load 2 dout", 32'(c3_dout), 32'hC3);
    check("c3 wrap", 32'(c3_wrap), 32'd0);

`ifdef MUX_SCAN_MASK_EN
    begin
      logic [1:0] ms [6];
      logic       mw [6];
      ms = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
      mw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      rst_n = 1'b0; mode = 1'b1; chan_mask = 4'b1010;
      @(posedge clk); #1;
      check("mask reset sel_out", 32'(sel_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        check($sformatf("mask step%0d sel_out", i), 32'(sel_out), 32'(ms[i]));
        check($sformatf("mask step%0d wrap", i), 32'(wrap), 32'(mw[i]));
      end
      @(negedge clk);
      chan_mask = 4'b0000;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check($sformatf("mask zero%0d sel_out", i), 32'(sel_out), 32'd1);
        check($sformatf("mask zero%0d dout_valid", i), 32'(dout_valid), 32'd0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel registered multiplexer with a built-in channel sequencer. It succeeds the team's 2:1 combinational mux. It selects one of CHANNELS input words of WIDTH bits, either under manual control or by automatically scanning the channels with a programmable dwell time. It sits between multi-source datapaths (sensor/ADC channels, status words) and a single downstream consumer that samples the registered `dout`.

## Interface
Parameters:
- `WIDTH`, 8, bits per channel word.
- `CHANNELS`, 4, number of input channels; legal range 2..256.
- `DWELL`, 1, cycles each channel is held in auto mode; legal range 1..65535.
- `SELW`, derived as `$clog2(CHANNELS)`, select width (not overridable).

Ports (one clock; reset is synchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset, sampled on `clk`.
- `din`  input  CHANNELS*WIDTH  flattened channel words; channel i is `din[i*WIDTH +: WIDTH]`.
- `mode`  input  1  0 = manual, 1 = auto scan.
- `sel_in`  input  SELW  channel index to load.
- `load_sel`  input  1  load `sel_in` into the select register this cycle.
- `chan_mask`  input  CHANNELS  per-channel scan enable; present only with `MUX_SCAN_MASK_EN`.
- `dout`  output  WIDTH  registered selected word.
- `dout_valid`  output  1  `dout` holds a captured word.
- `sel_out`  output  SELW  current select register `sel_q`.
- `wrap`  output  1  one-cycle pulse when the auto scan wraps to the lowest channel.

## Operation
- Reset (`rst_n`=0 at edge): `sel_q`=0, dwell counter=0, `dout`=0, `dout_valid`=0, `wrap`=0. Reset overrides every other input.
- Every cycle out of reset: `dout` <= `din[sel_q]`; `dout_valid` <= 1.
- Illegal `sel_in` (≥ CHANNELS) with `load_sel`=1: the load is ignored and `sel_q` holds. This is not an error condition.
- Manual mode (`mode`=0):
  - `sel_q` changes only on a legal `load_sel`.
  - The dwell counter is held at 0.
  - `wrap` stays 0.
- Auto mode (`mode`=1):
  - The dwell counter counts 0..DWELL-1.
  - In the cycle the counter equals DWELL-1, `sel_q` advances to the next channel and the counter returns to 0.
  - From CHANNELS-1 the next channel is 0, and `wrap` pulses 1 on that same edge.
- Legal `load_sel` in auto mode:
  - `sel_q` <= `sel_in` and the counter is cleared.
  - Load has priority over a coincident advance.
  - No `wrap` is generated on a load.
- Transition of `mode` 0→1 clears the dwell counter. The current channel then dwells a full DWELL cycles before advancing.
- Transition of `mode` 1→0 freezes `sel_q` at its current value.

## Timing
- `sel_in`/`load_sel` sampled at edge k updates `sel_out` at edge k. The corresponding `dout` appears at edge k+1 (2-cycle input-to-data latency).
- The `din` to `dout` path is registered with 1-cycle latency. `dout` is glitch-free across channel changes.
- In auto mode with DWELL=D, `sel_out` changes every D cycles, so a full scan takes CHANNELS*D cycles.
- `wrap` is high for exactly 1 cycle, aligned with `sel_out` becoming 0.
- `dout_valid` rises at the first edge after `rst_n` deasserts. It stays high until the next reset.

## Configuration
- Macro `MUX_SCAN_MASK_EN`.
- Defined:
  - The `chan_mask` port exists.
  - Auto advance skips channels whose mask bit is 0, choosing the next enabled channel in ascending order with wrap-around.
  - `wrap` pulses when the chosen index is lower than or equal to the current one.
  - All-zero mask: `sel_q` holds, the counter holds at 0, and `dout_valid` drops to 0 until a mask bit is set.
  - Manual loads ignore the mask.
- Undefined:
  - No `chan_mask` port.
  - All channels are scanned.
  - `dout_valid` never drops outside reset.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, DWELL=2, and `din` = {8'h44, 8'h33, 8'h22, 8'h11} (channel 3 down to channel 0).
- Reset: hold `rst_n`=0 for 3 cycles with arbitrary inputs -> `dout`=00, `dout_valid`=0, `sel_out`=0, `wrap`=0. First edge after release -> `dout`=11, `dout_valid`=1.
- Manual: `mode`=0, load `sel_in`=2 at edge k -> `sel_out`=2 at k, `dout`=33 at k+1. Load `sel_in`=5 (illegal, SELW=2 truncates to 1) is tested with CHANNELS=3: load 3 -> `sel_out` unchanged.
- Auto scan: `mode`=1 from reset -> `sel_out` sequence 0,0,1,1,2,2,3,3,0 and `dout` sequence 11,11,22,22,33,33,44,44,11 (one cycle behind `sel_out`). `wrap`=1 only on the 3→0 edge.
- Load vs advance collision: in auto mode, with the counter at DWELL-1 on channel 1, assert `load_sel` with `sel_in`=3 -> `sel_out`=3 (not 2), counter=0, `wrap`=0, `sel_out` holds 3 for the next 2 cycles.
- Mode switch and reset mid-scan: switch `mode` 1→0 on channel 2 -> `sel_out` stays 2 for 10 cycles. Assert `rst_n`=0 for 1 cycle mid-dwell -> all outputs return to reset values.
- With `MUX_SCAN_MASK_EN` and `chan_mask`=4'b1010, auto mode -> `sel_out` 1,1,3,3,1, with `wrap` on the 3→1 edge. Then `chan_mask`=0 -> `sel_out` holds and `dout_valid`=0.
